move_scheduler: RTL

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/game_pkg.sv | 30 +++
 rtl/move_scheduler_if.sv | 9 +
 rtl/dir_step.sv | 60 ++++++
 rtl/move_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared direction encodings, grid defaults and scheduler states
package game_pkg;

  typedef enum logic [2:0] {
    DIR_RIGHT = 3'b000,
    DIR_UP    = 3'b001,
    DIR_LEFT  = 3'b010,
    DIR_DOWN  = 3'b011,
    DIR_WAIT  = 3'b100
  } dir_t;

  localparam int GRID_W_DEF = 27;
  localparam int GRID_H_DEF = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_CUR,
    S_G1,
    S_G2,
    S_G3,
    S_DONE
  } state_t;

  // Only the four movement codes are steerable; WAIT and 101..111 never move.
  function automatic logic dir_legal(input logic [2:0] d);
    return (d[2] == 1'b0);
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// rtl/move_scheduler_if.sv - shared map lookup port (registered coordinates, combinational wall flag)
interface move_scheduler_if;
  logic [7:0] map_x;
  logic [6:0] map_y;
  logic       map_q;

  modport master (output map_x, output map_y, input map_q);
  modport slave  (input map_x, input map_y, output map_q);
endinterface

// File: rtl/dir_step.sv
// rtl/dir_step.sv - neighbour cell of (x,y) in a direction, wrapping at the grid edges
module dir_step
  import game_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] dir,
  output logic [7:0] nx,
  output logic [6:0] ny,
  output logic       wrap
);

  localparam logic [7:0] X_MAX = 8'(GRID_W - 1);
  localparam logic [6:0] Y_MAX = 7'(GRID_H - 1);

  always_comb begin
    nx   = x;
    ny   = y;
    wrap = 1'b0;
    case (dir)
      DIR_RIGHT: begin
        if (x == X_MAX) begin
          nx   = 8'd0;
          wrap = 1'b1;
        end else begin
          nx = x + 8'd1;
        end
      end
      DIR_UP: begin
        if (y == 7'd0) begin
          ny   = Y_MAX;
          wrap = 1'b1;
        end else begin
          ny = y - 7'd1;
        end
      end
      DIR_LEFT: begin
        if (x == 8'd0) begin
          nx   = X_MAX;
          wrap = 1'b1;
        end else begin
          nx = x - 8'd1;
        end
      end
      DIR_DOWN: begin
        if (y == Y_MAX) begin
          ny   = 7'd0;
          wrap = 1'b1;
        end else begin
          ny = y + 7'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - game tick generator and per-tick wall probe sequencer for pacman and three ghosts
module move_scheduler
  import game_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2:0]              dir_req,
  input  logic [8:0]              ghost_dir,
  input  logic [31:0]             ent_x,
  input  logic [27:0]             ent_y,
  move_scheduler_if.master        map,
  output logic [3:0]              step_en,
  output logic [11:0]             dir_out,
  output logic                    tick,
  output logic                    busy
);

  localparam int             CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    pending, pend_snap;
  logic [8:0]    g_snap;
  dir_t          cur_dir;
  logic [7:0]    map_x_r, nx;
  logic [6:0]    map_y_r, ny;
  logic          wrap, wrap_r;
  logic          probe_load;
  logic [1:0]    p_sel;
  logic [2:0]    p_dir, probe_dir;
  logic          pass;
  logic [7:0]    ex [4];
  logic [6:0]    ey [4];

  for (genvar i = 0; i < 4; i++) begin : g_ent
    assign ex[i] = ent_x[8*i +: 8];
    assign ey[i] = ent_y[7*i +: 7];
  end

  assign tick      = enable && (cnt == CNT_MAX);
  assign busy      = (state != S_IDLE);
  assign map.map_x = map_x_r;
  assign map.map_y = map_y_r;

  dir_step #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_dir_step (
    .x    (ex[p_sel]),
    .y    (ey[p_sel]),
    .dir  (p_dir),
    .nx   (nx),
    .ny   (ny),
    .wrap (wrap)
  );

  always_comb begin
    probe_dir = DIR_WAIT;
    case (state)
      S_PEND:  probe_dir = pend_snap;
      S_CUR:   probe_dir = cur_dir;
      S_G1:    probe_dir = g_snap[2:0];
      S_G2:    probe_dir = g_snap[5:3];
      S_G3:    probe_dir = g_snap[8:6];
      default: probe_dir = DIR_WAIT;
    endcase
  end

  // A wrapped neighbour is the tunnel, so the wall flag is ignored for it.
  assign pass = dir_legal(probe_dir) && (wrap_r || !map.map_q);

  // Next state also selects the probe for that state so map_x/map_y are registered in time.
  always_comb begin
    state_n    = state;
    probe_load = 1'b0;
    p_sel      = 2'd0;
    p_dir      = DIR_WAIT;
    case (state)
      S_IDLE: begin
        if (tick) begin
          state_n    = S_PEND;
          probe_load = 1'b1;
          p_sel      = 2'd0;
          p_dir      = pending;
        end
      end
      S_PEND: begin
        probe_load = 1'b1;
        if (pass) begin
          state_n = S_G1;
          p_sel   = 2'd1;
          p_dir   = g_snap[2:0];
        end else begin
          state_n = S_CUR;
          p_sel   = 2'd0;
          p_dir   = cur_dir;
        end
      end
      S_CUR: begin
        state_n    = S_G1;
        probe_load = 1'b1;
        p_sel      = 2'd1;
        p_dir      = g_snap[2:0];
      end
      S_G1: begin
        state_n    = S_G2;
        probe_load = 1'b1;
        p_sel      = 2'd2;
        p_dir      = g_snap[5:3];
      end
      S_G2: begin
        state_n    = S_G3;
        probe_load = 1'b1;
        p_sel      = 2'd3;
        p_dir      = g_snap[8:6];
      end
      S_G3:    state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pending   <= DIR_WAIT;
      pend_snap <= DIR_WAIT;
      g_snap    <= {DIR_WAIT, DIR_WAIT, DIR_WAIT};
      cur_dir   <= DIR_WAIT;
      dir_out   <= 12'b100100100100;
      step_en   <= 4'b0000;
      map_x_r   <= 8'd0;
      map_y_r   <= 7'd0;
      wrap_r    <= 1'b0;
    end else begin
      state   <= state_n;
      step_en <= 4'b0000;

      if (!enable || cnt == CNT_MAX) cnt <= '0;
      else                           cnt <= cnt + CW'(1);

      if (dir_legal(dir_req)) pending <= dir_req;

      if (state == S_IDLE && tick) begin
        pend_snap <= pending;
        g_snap    <= ghost_dir;
      end

      if (probe_load) begin
        map_x_r <= nx;
        map_y_r <= ny;
        wrap_r  <= wrap;
      end

      case (state)
        S_PEND: begin
          if (pass) begin
            cur_dir      <= dir_t'(pend_snap);
            dir_out[2:0] <= pend_snap;
            step_en[0]   <= 1'b1;
          end
        end
        S_CUR: begin
          step_en[0]   <= pass;
          dir_out[2:0] <= pass ? 3'(cur_dir) : 3'(DIR_WAIT);
        end
        S_G1: begin
          step_en[1]   <= pass;
          dir_out[5:3] <= pass ? g_snap[2:0] : 3'(DIR_WAIT);
        end
        S_G2: begin
          step_en[2]   <= pass;
          dir_out[8:6] <= pass ? g_snap[5:3] : 3'(DIR_WAIT);
        end
        S_G3: begin
          step_en[3]    <= pass;
          dir_out[11:9] <= pass ? g_snap[8:6] : 3'(DIR_WAIT);
        end
        default: ;
      endcase
    end
  end

endmodule
